// File: rtl/off_chip_rx_pkg.sv
// Shared types and defaults for the off-chip receive buffer.
// MARKER_BYTE is the same value that the link stage's own marker counter tracks.
package off_chip_rx_pkg;

  typedef logic [7:0] byte_t;

  localparam int DEFAULT_DEPTH        = 8;
  localparam int DEFAULT_AFULL_MARGIN = 2;
  localparam byte_t MARKER_BYTE       = 8'd5;

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH x 8 storage array for the receive buffer.
// It has one synchronous write port and one combinational read port.
// The contents are not reset, because the pointers in the top level decide what is valid.
module rx_fifo_mem
  import off_chip_rx_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  byte_t         wr_data,
  input  logic [AW-1:0] rd_addr,
  output byte_t         rd_data
);

  byte_t mem [DEPTH];

  // Write port: store the incoming byte at the write address.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/off_chip_rx_buffer.sv
// Receive-side elastic buffer between link reassembly and the on-chip consumer.
// Storage is a DEPTH-entry array plus one output register. in_ready is registered
// and drops early enough that the link's one-cycle lag never overruns the array.
// Optional feature: define RX_MARKER_CNT_EN to add the marker_cnt port and its counter.
module off_chip_rx_buffer
  import off_chip_rx_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int AFULL_MARGIN = DEFAULT_AFULL_MARGIN
`ifdef RX_MARKER_CNT_EN
  ,
  parameter byte_t MARKER    = MARKER_BYTE
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  byte_t                      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output byte_t                      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
`ifdef RX_MARKER_CNT_EN
  ,
  output logic [$clog2(DEPTH+2)-1:0] marker_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW:0]   wptr, rptr;
  logic [CW-1:0] count_next;
  logic          accept, pop, out_free, arr_empty, arr_full;
  logic          bypass, refill, drop, wr_en;
  byte_t         head_data;

  rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr[AW-1:0]),
    .wr_data (in_data),
    .rd_addr (rptr[AW-1:0]),
    .rd_data (head_data)
  );

  assign count = wptr - rptr;

  // Route each accepted byte. It either bypasses into the output register or is queued in the array.
  // A byte is dropped only if it arrives while the array is full and the output register is not draining.
  always_comb begin
    accept     = in_valid & in_ready;
    pop        = out_valid & out_ready;
    out_free   = ~out_valid | pop;
    arr_empty  = (wptr == rptr);
    arr_full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    bypass     = accept & arr_empty & out_free;
    refill     = ~arr_empty & out_free;
    drop       = accept & arr_full & ~refill;
    wr_en      = accept & ~bypass & ~drop;
    count_next = count + CW'(wr_en) - CW'(refill);
  end

  // Advance the write and read pointers. The extra wrap bit tells full apart from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en)  wptr <= wptr + 1'b1;
      if (refill) rptr <= rptr + 1'b1;
    end
  end

  // Output register: refill it from the array head, or load it directly on bypass.
  // It empties when a pop leaves nothing behind to replace the byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (refill) begin
      out_valid <= 1'b1;
      out_data  <= head_data;
    end else if (bypass) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

  // Register in_ready from the post-edge occupancy. Also record any dropped byte in the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;
      overflow <= 1'b0;
    end else begin
      in_ready <= (count_next <= CW'(DEPTH - AFULL_MARGIN));
      overflow <= overflow | drop;
    end
  end

`ifdef RX_MARKER_CNT_EN
  logic mark_in, mark_out;

  assign mark_in  = accept & ~drop & (in_data == MARKER);
  assign mark_out = pop & (out_data == MARKER);

  // Count the MARKER bytes held in the array plus the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      marker_cnt <= '0;
    end else if (mark_in & ~mark_out) begin
      marker_cnt <= marker_cnt + 1'b1;
    end else if (mark_out & ~mark_in) begin
      marker_cnt <= marker_cnt - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_off_chip_rx_buffer.sv
// Self-checking bench for off_chip_rx_buffer.
// The reference model is a queue of every byte the buffer holds. The head of the queue is the output register.
// Honours RX_MARKER_CNT_EN when it is defined.
module tb_off_chip_rx_buffer;
  import off_chip_rx_pkg::*;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic  clk = 1'b0;
  logic  rst;
  byte_t in_data, out_data;
  logic  in_valid, in_ready, out_valid, out_ready, overflow;
  logic [3:0] count;

  byte_t f_in_data, f_out_data;
  logic  f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_overflow;
  logic [3:0] f_count;

`ifdef RX_MARKER_CNT_EN
  logic [3:0] marker_cnt, f_marker_cnt;
`endif

  off_chip_rx_buffer #(.DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .overflow   (overflow)
`ifdef RX_MARKER_CNT_EN
    ,
    .marker_cnt (marker_cnt)
`endif
  );

  // The margin is relaxed to zero here so that the array can really fill.
  // That lets the full-with-pop and overflow paths be exercised.
  off_chip_rx_buffer #(.DEPTH(DEPTH), .AFULL_MARGIN(0)) dut_full (
    .clk        (clk),
    .rst        (rst),
    .in_data    (f_in_data),
    .in_valid   (f_in_valid),
    .in_ready   (f_in_ready),
    .out_data   (f_out_data),
    .out_valid  (f_out_valid),
    .out_ready  (f_out_ready),
    .count      (f_count),
    .overflow   (f_overflow)
`ifdef RX_MARKER_CNT_EN
    ,
    .marker_cnt (f_marker_cnt)
`endif
  );

  always #5 clk = ~clk;

  byte_t held[$];
  byte_t tx[$];
  byte_t popped[$];
  byte_t exp_q[$];
  logic  m_ready;
  logic  gap;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int exp_cnt;
    exp_cnt = (held.size() == 0) ? 0 : held.size() - 1;
    check("in_ready", in_ready, m_ready);
    check("out_valid", out_valid, held.size() > 0);
    check("count", count, exp_cnt);
    check("overflow", overflow, 1'b0);
    if (held.size() > 0) check("out_data", out_data, held[0]);
`ifdef RX_MARKER_CNT_EN
    begin
      int m;
      m = 0;
      foreach (held[k]) if (held[k] == MARKER_BYTE) m++;
      check("marker_cnt", marker_cnt, m);
    end
`endif
  endtask

  task automatic modelEdge();
    logic acc, pp;
    int   occ;
    acc = in_valid & m_ready;
    pp  = out_ready & (held.size() > 0);
    if (pp) popped.push_back(held.pop_front());
    if (acc) begin
      held.push_back(in_data);
      void'(tx.pop_front());
      gap = 1'b1;
    end else begin
      gap = 1'b0;
    end
    occ = (held.size() == 0) ? 0 : held.size() - 1;
    m_ready = (occ <= DEPTH - MARGIN);
  endtask

  // or_mode: 0 = consumer stalled, 1 = always ready, 2 = random backpressure
  task automatic applyStimulus(input int n, input int or_mode);
    for (int i = 0; i < n; i++) begin
      if (tx.size() > 0 && !gap) begin
        in_valid = 1'b1;
        in_data  = tx[0];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput();
    end
  endtask

  task automatic stepFull();
    @(posedge clk);
    #1;
  endtask

  task automatic checkQueue(input string tag);
    check({tag, "_len"}, popped.size(), exp_q.size());
    foreach (exp_q[k]) begin
      if (k < popped.size()) check(tag, popped[k], exp_q[k]);
    end
  endtask

  initial begin
    byte_t fb[10];
    byte_t b;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    f_in_valid = 1'b0; f_in_data = '0; f_out_ready = 1'b0;
    gap = 1'b0; m_ready = 1'b0;

    $display("[TB] reset values");
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_count", count, 4'd0);
    check("rst_overflow", overflow, 1'b0);
`ifdef RX_MARKER_CNT_EN
    check("rst_marker", marker_cnt, 4'd0);
`endif
    rst = 1'b0;
    #1;
    check("in_ready_before_edge", in_ready, 1'b0);
    applyStimulus(1, 1);

    $display("[TB] single byte bypass");
    tx = '{8'hA3};
    applyStimulus(1, 1);
    check("bypass_valid", out_valid, 1'b1);
    check("bypass_data", out_data, 8'hA3);
    check("bypass_count", count, 4'd0);
    applyStimulus(3, 1);

    $display("[TB] backpressure fill then drain");
    popped.delete();
    tx.delete(); exp_q.delete();
    for (int i = 1; i <= 10; i++) begin
      tx.push_back(8'(i));
      exp_q.push_back(8'(i));
    end
    applyStimulus(30, 0);
    check("fill_count", count, 4'd7);
    check("fill_ready_low", in_ready, 1'b0);
    check("fill_head", out_data, 8'h01);
    applyStimulus(40, 1);
    checkQueue("fill_order");

    $display("[TB] streaming with pointer wrap");
    popped.delete(); exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      tx.push_back(b);
      exp_q.push_back(b);
    end
    applyStimulus(45, 1);
    checkQueue("stream_order");

    $display("[TB] random traffic with backpressure");
    popped.delete(); exp_q.delete();
    for (int i = 0; i < 60; i++) begin
      b = ($urandom_range(0, 3) == 0) ? MARKER_BYTE : 8'($urandom);
      tx.push_back(b);
      exp_q.push_back(b);
    end
    applyStimulus(200, 2);
    applyStimulus(150, 1);
    checkQueue("random_order");

    $display("[TB] reset mid-transfer");
    tx.delete();
    for (int i = 0; i < 6; i++) tx.push_back(8'($urandom));
    applyStimulus(14, 0);
    check("pre_rst_count", count, 4'd5);
    check("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_count", count, 4'd0);
    held.delete(); tx.delete(); popped.delete();
    gap = 1'b0; m_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    b = 8'($urandom);
    tx = '{b};
    applyStimulus(3, 1);
    check("post_rst_len", popped.size(), 1);
    if (popped.size() > 0) check("post_rst_byte", popped[0], b);

`ifdef RX_MARKER_CNT_EN
    $display("[TB] marker conservation");
    tx = '{MARKER_BYTE, 8'h07, MARKER_BYTE};
    applyStimulus(8, 0);
    check("marker_two", marker_cnt, 4'd2);
    tx = '{MARKER_BYTE};
    applyStimulus(1, 1);
    check("marker_swap", marker_cnt, 4'd2);
    applyStimulus(10, 1);
    check("marker_drained", marker_cnt, 4'd0);
`endif

    $display("[TB] full array with pop, then overflow");
    foreach (fb[k]) fb[k] = 8'($urandom);
    f_out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      f_in_valid = 1'b1; f_in_data = fb[i];
      stepFull();
      f_in_valid = 1'b0;
      stepFull();
    end
    check("full_count", f_count, 4'd8);
    check("full_ready", f_in_ready, 1'b1);
    check("full_head", f_out_data, fb[0]);
    f_in_valid = 1'b1; f_in_data = fb[9]; f_out_ready = 1'b1;
    stepFull();
    f_in_valid = 1'b0; f_out_ready = 1'b0;
    check("full_pop_count", f_count, 4'd8);
    check("full_pop_overflow", f_overflow, 1'b0);
    check("full_pop_head", f_out_data, fb[1]);
    stepFull();
    f_in_valid = 1'b1; f_in_data = ~fb[9];
    stepFull();
    f_in_valid = 1'b0;
    check("drop_overflow", f_overflow, 1'b1);
    check("drop_count", f_count, 4'd8);
    check("drop_head", f_out_data, fb[1]);
    f_out_ready = 1'b1;
    for (int i = 1; i < 10; i++) begin
      check("full_drain_valid", f_out_valid, 1'b1);
      check("full_drain_data", f_out_data, fb[i]);
      stepFull();
    end
    check("full_empty_valid", f_out_valid, 1'b0);
    check("full_empty_count", f_count, 4'd0);
    check("overflow_sticky", f_overflow, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
